// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the dual-clock FIFO: round-robin, bounded-length bursts
// from a single pop/data port to N_REQ consumers in the rd_clk domain.
module fifo_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8,
  parameter int EMPTY_TO  = 4
) (
  input  logic                     rd_clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rdy,
  input  logic                     fifo_empty,
  input  logic [DW-1:0]            fifo_data,
  output logic                     fifo_pop,
  output logic [N_REQ-1:0]         gnt,
  output logic [DW-1:0]            data_o,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] vld_id_o,
  output logic                     done_o,
  output logic [7:0]               beats_o
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    vld_id_q, vld_id_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       beats_q, beats_d;
  logic [3:0]       to_cnt_q, to_cnt_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             pop, stall, last_pop, term, finish, found;
  logic [IW-1:0]    idx;

  assign pop      = (state_q == BURST) && !fifo_empty && rdy[cur_id_q] &&
                    (cnt_q < 8'(MAX_BURST));
  assign stall    = fifo_empty && rdy[cur_id_q];
  assign last_pop = pop && ((cnt_q + 8'd1) == 8'(MAX_BURST));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cur_id_d = cur_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    beats_d  = beats_q;
    valid_d  = pop;
    vld_id_d = cur_id_q;
    done_d   = 1'b0;
    found    = 1'b0;
    idx      = '0;
    term     = 1'b0;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        // Rotating search: the first requester at or after ptr wins.
        for (int unsigned i = 0; i < N_REQ; i++) begin
          idx = IW'((32'(ptr_q) + i) % N_REQ);
          if (!found && req[idx]) begin
            found       = 1'b1;
            cur_id_d    = idx;
            gnt_d       = '0;
            gnt_d[idx]  = 1'b1;
            state_d     = BURST;
          end
        end
      end
      BURST: begin
        if (pop) begin
          cnt_d    = cnt_q + 8'd1;
          to_cnt_d = '0;
        end else if (stall && (to_cnt_q < 4'(EMPTY_TO))) begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
        term = last_pop || !req[cur_id_q] || (to_cnt_d == 4'(EMPTY_TO));
        // A pop in the terminating cycle still owes its beat, so DRAIN first.
        if (term && pop) state_d = DRAIN;
        finish = term && !pop;
      end
      DRAIN:   finish = 1'b1;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d  = IDLE;
      gnt_d    = '0;
      done_d   = 1'b1;
      beats_d  = cnt_q;
      ptr_d    = (cur_id_q == IW'(N_REQ - 1)) ? '0 : cur_id_q + IW'(1);
      cnt_d    = '0;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cur_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      beats_q  <= '0;
      valid_q  <= 1'b0;
      vld_id_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cur_id_q <= cur_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      beats_q  <= beats_d;
      valid_q  <= valid_d;
      vld_id_q <= vld_id_d;
      done_q   <= done_d;
    end
  end

  assign fifo_pop = pop;
  assign gnt      = gnt_q;
  assign data_o   = fifo_data;
  assign valid_o  = valid_q;
  assign vld_id_o = vld_id_q;
  assign done_o   = done_q;
  assign beats_o  = beats_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a queue-based FIFO, a burst-level behavioural model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fifo_rd_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 8;
  localparam int ETO  = 4;

  logic          rd_clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, rdy;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic [N-1:0]  gnt;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic [1:0]    vld_id_o;
  logic          done_o;
  logic [7:0]    beats_o;

  fifo_rd_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAXB), .EMPTY_TO(ETO)) dut (
    .rd_clk(rd_clk), .reset(reset), .req(req), .rdy(rdy),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .gnt(gnt), .data_o(data_o), .valid_o(valid_o), .vld_id_o(vld_id_o),
    .done_o(done_o), .beats_o(beats_o)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  int fq[$];
  int vq[$], dq[$], gq[$];
  int next_word;
  bit pop_seen;
  logic [N-1:0] prev_gnt;

  // Model: who owns the port, whether only the final beat is outstanding,
  // and what the outputs must show after the next edge.
  bit   m_busy, m_drain;
  int   m_own, m_ptr, m_cnt, m_stall;
  logic [N-1:0] e_gnt;
  bit   e_valid, e_done;
  int   e_id, e_data, e_beats;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qv(input int i);
    return (i < vq.size()) ? vq[i] : -1;
  endfunction
  function automatic int qd(input int i);
    return (i < dq.size()) ? dq[i] : -1;
  endfunction
  function automatic int qg(input int i);
    return (i < gq.size()) ? gq[i] : -1;
  endfunction

  task automatic clear_logs();
    vq.delete(); dq.delete(); gq.delete();
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
    e_gnt = '0; e_valid = 0; e_done = 0; e_id = 0; e_data = 0; e_beats = 0;
  endtask

  function automatic bit model_pop();
    return m_busy && !m_drain && !fifo_empty && rdy[m_own] && (m_cnt < MAXB);
  endfunction

  task automatic finish_burst();
    m_busy = 0; m_drain = 0;
    e_gnt = '0; e_done = 1; e_beats = m_cnt;
    m_ptr = (m_own + 1) % N;
    m_cnt = 0; m_stall = 0;
  endtask

  task automatic model_step();
    bit p, ended, found;
    int w;
    p = model_pop();
    e_done = 0;
    e_valid = p;
    if (p) begin
      e_id = m_own;
      e_data = fq[0];
    end
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (!found && req[w]) begin
          found = 1; m_busy = 1; m_own = w;
          e_gnt = '0; e_gnt[w] = 1'b1;
        end
      end
    end else if (m_drain) begin
      finish_burst();
    end else begin
      ended = 0;
      if (p) begin
        m_cnt++; m_stall = 0;
        if (m_cnt == MAXB) ended = 1;
      end else if (fifo_empty && rdy[m_own]) begin
        m_stall++;
      end
      if (!req[m_own]) ended = 1;
      if (m_stall >= ETO) ended = 1;
      if (ended) begin
        if (p) m_drain = 1;
        else finish_burst();
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] y, input int push);
    @(negedge rd_clk);
    if (pop_seen && fq.size() > 0) fifo_data = DW'(fq.pop_front());
    for (int k = 0; k < push; k++) begin
      fq.push_back(next_word & 255);
      next_word++;
    end
    fifo_empty = (fq.size() == 0);
    req = r;
    rdy = y;
    #1;
    check("gnt", int'(gnt), int'(e_gnt));
    check("valid_o", int'(valid_o), int'(e_valid));
    if (e_valid) begin
      check("vld_id_o", int'(vld_id_o), e_id);
      check("data_o", int'(data_o), e_data);
    end
    check("done_o", int'(done_o), int'(e_done));
    check("beats_o", int'(beats_o), e_beats);
    check("fifo_pop", int'(fifo_pop), int'(model_pop()));
    if (valid_o) vq.push_back(int'(data_o));
    if (done_o) dq.push_back(int'(beats_o));
    if (gnt != '0 && prev_gnt == '0)
      for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
    prev_gnt = gnt;
    model_step();
    pop_seen = fifo_pop;
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    if (pop_seen && fq.size() > 0) fifo_data = DW'(fq.pop_front());
    reset = 1'b0;
    req = '0;
    rdy = '0;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_vld_id", int'(vld_id_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_beats", int'(beats_o), 0);
    check("rst_pop", int'(fifo_pop), 0);
    model_reset();
    pop_seen = 0;
    prev_gnt = '0;
    fq.delete();
    fifo_empty = 1'b1;
    repeat (2) @(negedge rd_clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rq, ry, flip;
    int fill;
    reset = 1'b0; req = '0; rdy = '0; fifo_empty = 1'b1; fifo_data = '0;
    next_word = 0; pop_seen = 0; prev_gnt = '0;
    model_reset();
    do_reset();

    // Single requester, two full bursts from a preloaded FIFO.
    clear_logs(); next_word = 16;
    cycle('0, '1, 16);
    repeat (21) cycle(4'b0001, '1, 0);
    repeat (10) cycle('0, '1, 0);
    check("t1_grant", qg(0), 0);
    check("t1_beats_a", qd(0), 8);
    check("t1_beats_b", qd(1), 8);
    check("t1_nbeats", vq.size(), 16);
    check("t1_first", qv(0), 16);
    check("t1_eighth", qv(7), 23);
    check("t1_ninth", qv(8), 24);
    check("t1_last", qv(15), 31);

    // All requesting, FIFO kept fed: round-robin order.
    do_reset(); clear_logs(); next_word = 64;
    cycle('0, '1, 4);
    repeat (48) cycle(4'b1111, '1, 1);
    repeat (12) cycle('0, '1, 1);
    for (int k = 0; k < 5; k++) check("t2_order", qg(k), k % 4);
    for (int k = 0; k < 4; k++) check("t2_beats", qd(k), 8);

    // Three words then empty: timeout ends the burst; pointer moves past 2.
    do_reset(); clear_logs(); next_word = 48;
    cycle('0, '1, 3);
    repeat (8) cycle(4'b0100, '1, 0);
    cycle(4'b1111, '1, 0);
    repeat (8) cycle('0, '1, 0);
    check("t3_beats", qd(0), 3);
    check("t3_nbeats", vq.size(), 3);
    check("t3_grant_a", qg(0), 2);
    check("t3_grant_b", qg(1), 3);

    // rdy[1] pauses issue mid-burst without ending it.
    do_reset(); clear_logs(); next_word = 64;
    cycle('0, '1, 16);
    repeat (3) cycle(4'b0010, '1, 0);
    repeat (2) cycle(4'b0010, 4'b1101, 0);
    repeat (6) cycle(4'b0010, '1, 0);
    repeat (6) cycle('0, '1, 0);
    check("t4_beats", qd(0), 8);
    check("t4_ndone", dq.size(), 1);
    check("t4_nbeats", vq.size(), 8);

    // req dropped on the second pop: final beat arrives in DRAIN.
    do_reset(); clear_logs(); next_word = 80;
    cycle('0, '1, 8);
    repeat (2) cycle(4'b0001, '1, 0);
    repeat (6) cycle('0, '1, 0);
    check("t5_beats", qd(0), 2);
    check("t5_nbeats", vq.size(), 2);
    check("t5_last", qv(1), 81);

    // Reset with a beat in flight, pointer non-zero beforehand.
    clear_logs();
    cycle('0, '1, 8);
    repeat (3) cycle(4'b0010, '1, 0);
    check("t6_pre_grant", qg(0), 1);
    do_reset(); clear_logs();
    repeat (3) cycle(4'b1111, '1, 0);
    repeat (8) cycle('0, '1, 0);
    check("t6_post_grant", qg(0), 0);

    // Random traffic with persistent requests and varying fill rate.
    do_reset(); clear_logs();
    rq = '0; fill = 1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) fill = $urandom_range(0, 3);
      flip = '0;
      for (int k = 0; k < N; k++) flip[k] = ($urandom_range(0, 7) == 0);
      rq = rq ^ flip;
      for (int k = 0; k < N; k++) ry[k] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle(rq, ry, (fq.size() < 64) ? $urandom_range(0, fill) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
